// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with result flags and a
// completed-transfer counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_load_c;
  logic             s1_load_c;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic [WIDTH-1:0] res_c;
  logic             zero_c;
  logic             ones_c;

  // S2 frees up when empty or drained this cycle; S1 follows S2.
  assign out_xfer_c = out_valid & out_ready;
  assign s2_load_c  = ~out_valid | out_ready;
  assign s1_load_c  = ~s1_valid | s2_load_c;
  assign in_ready   = ~rst & s1_load_c;
  assign in_xfer_c  = in_valid & in_ready;

  // Bitwise operation on the S1 operands.
  always_comb begin
    res_c = '0;
    unique case (s1_op)
      OP_NOT:  res_c = ~s1_a;
      OP_AND:  res_c = s1_a & s1_b;
      OP_OR:   res_c = s1_a | s1_b;
      OP_XOR:  res_c = s1_a ^ s1_b;
      OP_NAND: res_c = ~(s1_a & s1_b);
      OP_NOR:  res_c = ~(s1_a | s1_b);
      OP_XNOR: res_c = ~(s1_a ^ s1_b);
      OP_PASS: res_c = s1_a;
      default: res_c = '0;
    endcase
    zero_c = (res_c == '0);
    ones_c = &res_c;
  end

  // S1: operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOT;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_xfer_c;
      if (in_xfer_c) begin
        s1_op <= op_e'(op);
        s1_a  <= data_in;
        s1_b  <= data_in_b;
      end
    end
  end

  // S2: result, flags and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (out_xfer_c) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
      if (s2_load_c) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          res  <= res_c;
          zero <= zero_c;
          ones <= ones_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed spec vectors plus
// randomized traffic against a queue-based reference model.
module tb_logic_unit_pipe;

  localparam int unsigned W = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  res;
  logic          zero;
  logic          ones;
  logic [15:0]   done_cnt;

  logic          w_in_ready;
  logic          w_out_valid;
  logic [W-1:0]  w_res;
  logic          w_zero;
  logic          w_ones;
  logic [1:0]    w_done_cnt;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data_in(a), .data_in_b(b), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .ones(ones),
    .done_cnt(done_cnt)
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .data_in(a), .data_in_b(b), .out_valid(w_out_valid),
    .out_ready(out_ready), .res(w_res), .zero(w_zero), .ones(w_ones),
    .done_cnt(w_done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   model_cnt = 0;
  int   cnt_before = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   acc_cyc[$];
  int   out_cyc[$];
  logic rdy_s;
  logic ov_s;
  logic [15:0] dc_s;
  logic [1:0]  dcw_s;

  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    res_t m;
    case (o)
      3'd0:    m.r = ~x;
      3'd1:    m.r = x & y;
      3'd2:    m.r = x | y;
      3'd3:    m.r = x ^ y;
      3'd4:    m.r = ~(x & y);
      3'd5:    m.r = ~(x | y);
      3'd6:    m.r = ~(x ^ y);
      default: m.r = x;
    endcase
    m.z = (m.r == '0);
    m.o = (m.r == {W{1'b1}});
    return m;
  endfunction

  // One clock: sample at negedge, record transfers, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    rdy_s = in_ready;
    ov_s  = out_valid;
    dc_s  = done_cnt;
    dcw_s = w_done_cnt;
    cnt_before = model_cnt;
    if (rst) begin
      exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
      model_cnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back('{res, zero, ones});
        out_cyc.push_back(cyc);
        model_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((got_q.size() < exp_q.size() || out_valid) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", rdy_s); end
    total++; if (ov_s !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov_s); end
    total++; if (res !== '0) begin bad++; $display("FAIL reset_res got=%h exp=0", res); end
    total++; if (zero !== 1'b0 || ones !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", zero, ones); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (rdy_s !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", rdy_s); end
  endtask

  task automatic test_not_sweep();
    logic [W-1:0] nin [4];
    logic [W-1:0] nexp [4];
    logic         nz [4];
    logic         no [4];
    int n;
    nin  = '{10'b0000000000, 10'b1111111111, 10'b0101010101, 10'b1010101010};
    nexp = '{10'b1111111111, 10'b0000000000, 10'b1010101010, 10'b0101010101};
    nz   = '{1'b0, 1'b1, 1'b0, 1'b0};
    no   = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_q.delete(); exp_q.delete(); acc_cyc.delete(); out_cyc.delete();
      in_valid = 1'b1; op = 3'b000; a = nin[i]; b = W'($urandom);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (got_q.size() == 0 && n < 10) begin tick(); n++; end
      total++;
      if (got_q.size() != 1 || acc_cyc.size() != 1) begin
        bad++; $display("FAIL not_count[%0d] got=%0d exp=1", i, got_q.size());
      end else begin
        if (out_cyc[0] - acc_cyc[0] != 2) begin
          bad++; $display("FAIL not_latency[%0d] got=%0d exp=2", i, out_cyc[0] - acc_cyc[0]);
        end
        total++;
        if (got_q[0].r !== nexp[i] || got_q[0].z !== nz[i] || got_q[0].o !== no[i]) begin
          bad++;
          $display("FAIL not_res[%0d] got=%b z=%b o=%b exp=%b z=%b o=%b", i,
                   got_q[0].r, got_q[0].z, got_q[0].o, nexp[i], nz[i], no[i]);
        end
      end
    end
  endtask

  task automatic test_binary_ops();
    logic [W-1:0] bexp [6];
    bexp = '{10'b1000100010, 10'b1110111011, 10'b0110011001,
             10'b0111011101, 10'b0001000100, 10'b1001100110};
    do_reset();
    out_ready = 1'b1;
    for (int o = 1; o <= 6; o++) begin
      in_valid = 1'b1; op = 3'(o); a = 10'b1100110011; b = 10'b1010101010;
      tick();
    end
    drain();
    total++;
    if (got_q.size() != 6) begin
      bad++; $display("FAIL bin_count got=%0d exp=6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (got_q[i].r !== bexp[i] || got_q[i].z !== 1'b0 || got_q[i].o !== 1'b0) begin
          bad++; $display("FAIL bin_op%0d got=%b exp=%b", i + 1, got_q[i].r, bexp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int n;
    logic [W-1:0] held;
    do_reset();
    out_ready = 1'b0;
    acc = 0; held = '0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      tick();
      if (rdy_s) begin
        acc++;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
      if (k == 2) held = res;
    end
    total++; if (acc != 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", acc); end
    total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", rdy_s); end
    total++; if (ov_s !== 1'b1 || res !== held) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", ov_s, res, held); end
    out_ready = 1'b1;
    n = 0;
    while (acc < 4 && n < 20) begin
      in_valid = 1'b1;
      tick();
      if (rdy_s) begin
        acc++;
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
      n++;
    end
    drain();
    tick();
    total++; if (dc_s !== 16'd4) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=4", dc_s); end
    total++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (got_q[i] != exp_q[i]) begin
          bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i].r, exp_q[i].r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic all_rdy;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; all_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      tick();
      if (rdy_s !== 1'b1) all_rdy = 1'b0;
    end
    in_valid = 1'b0;
    total++; if (all_rdy !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=0 exp=1"); end
    total++;
    if (got_q.size() != 18) begin
      bad++; $display("FAIL b2b_count got=%0d exp=18", got_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        if (got_q[i] != exp_q[i] || out_cyc[i] != out_cyc[0] + i) begin
          bad++; $display("FAIL b2b_item[%0d] got=%h@%0d exp=%h@%0d", i,
                          got_q[i].r, out_cyc[i], exp_q[i].r, out_cyc[0] + i);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic pv, pr;
    logic [W-1:0] pres;
    int errs;
    do_reset();
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      pv = out_valid; pr = out_ready; pres = res;
      tick();
      if (pv && !pr && (out_valid !== 1'b1 || res !== pres)) begin
        errs++; $display("FAIL rnd_stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, res, pres);
      end
      if (dc_s !== 16'(cnt_before) || dcw_s !== 2'(cnt_before)) begin
        errs++; $display("FAIL rnd_done_cnt got=%0d/%0d exp=%0d", dc_s, dcw_s, cnt_before);
      end
    end
    total++; if (errs != 0) bad++;
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      errs = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i] != exp_q[i]) begin
          errs++; $display("FAIL rnd_item[%0d] got=%h z=%b o=%b exp=%h z=%b o=%b", i,
                           got_q[i].r, got_q[i].z, got_q[i].o, exp_q[i].r, exp_q[i].z, exp_q[i].o);
        end
      end
      if (errs != 0) bad++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      tick();
    end
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
    end
    total++; if (ov_s !== 1'b1 || rdy_s !== 1'b0) begin bad++; $display("FAIL mid_full got=%b%b exp=10", ov_s, rdy_s); end
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || done_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset got=%b/%0d exp=0/0", out_valid, done_cnt); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_wrap();
    int wseq [5];
    int n;
    wseq = '{1, 2, 3, 0, 1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (got_q.size() < i + 1 && n < 10) begin tick(); n++; end
      total++;
      if (int'(w_done_cnt) != wseq[i] || int'(done_cnt) != i + 1) begin
        bad++; $display("FAIL wrap[%0d] got=%0d/%0d exp=%0d/%0d", i, w_done_cnt, done_cnt, wseq[i], i + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    test_reset();
    test_not_sweep();
    test_binary_ops();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
